wave_sequencer: RTL

- Playlist scheduler that sequences the waveform datapath with no key presses needed.
- Steps through a programmable table of segments. Each segment sets wave select, frequency select, amplitude select and noise enable, and lasts a set number of sample ticks.
- Its outputs drive the datapath's wave-select, freq_wave, amp_wave and noise_enable controls in place of the switch/key sources.
- It also emits a phase-realign pulse at each segment boundary.

---
 rtl/wave_sequencer_pkg.sv | 28 ++
 rtl/wave_sequencer_playlist_ram.sv | 28 ++
 rtl/wave_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wave_sequencer_pkg.sv
// Shared definitions for the playlist sequencer: FSM states, playlist entry
// layout and the waveform-select codes understood by the waveform mux.
package wave_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  // Entry layout: {dur, wave_sel[2:0], freq_sel[1:0], amp_sel[1:0], noise_en}
  localparam int CFG_W   = 8;
  localparam int DUR_LSB = CFG_W;

  typedef struct packed {
    logic [2:0] wave_sel;
    logic [1:0] freq_sel;
    logic [1:0] amp_sel;
    logic       noise_en;
  } seg_cfg_t;

  localparam logic [2:0] WAVE_SINE     = 3'd0;
  localparam logic [2:0] WAVE_SQUARE   = 3'd1;
  localparam logic [2:0] WAVE_TRIANGLE = 3'd2;
  localparam logic [2:0] WAVE_ECG      = 3'd3;
  localparam logic [2:0] WAVE_SAWTOOTH = 3'd4;

endpackage

// File: rtl/wave_sequencer_playlist_ram.sv
// Playlist storage: one synchronous write port and one registered read port.
// A same-address read and write in one cycle returns the old contents.
module seq_playlist_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_sequencer.sv
// Playlist scheduler: steps through programmed segments, driving the waveform
// datapath controls and pulsing phase_rst whenever a new segment is applied.
module wave_sequencer
  import wave_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW+7:0]   wr_data,
  input  logic [AW:0]     num_entries,
  input  logic            loop_en,
  input  logic            start,
  input  logic            stop,
  output logic [2:0]      wave_sel,
  output logic [1:0]      freq_wave,
  output logic [1:0]      amp_wave,
  output logic            noise_enable,
  output logic            phase_rst,
  output logic            busy,
  output logic [AW-1:0]   entry_idx,
  output logic            seg_done,
  output logic            seq_done
);

  seq_state_e      state_q, state_d;
  seg_cfg_t        cfg_q, cfg_d;
  logic [AW-1:0]   entry_idx_q, entry_idx_d;
  logic [AW-1:0]   load_idx_q, load_idx_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            phase_rst_q, phase_rst_d;
  logic            seg_done_q, seg_done_d;
  logic            seq_done_q, seq_done_d;
  logic [DW+7:0]   rd_data;
  logic [DW-1:0]   rd_dur;
  logic            num_ok;
  logic            last_entry;

  seq_playlist_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (DW + 8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (load_idx_d),
    .rd_data (rd_data)
  );

  assign rd_dur = rd_data[DUR_LSB +: DW];
  assign num_ok = (num_entries != '0) && (num_entries <= (AW+1)'(DEPTH));
  // num_entries is live, so a shrink below the current index ends the pass here
  assign last_entry = (num_entries == '0) ||
                      ({1'b0, entry_idx_q} >= (num_entries - 1'b1));

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    entry_idx_d = entry_idx_q;
    load_idx_d  = load_idx_q;
    cnt_d       = cnt_q;
    phase_rst_d = 1'b0;
    seg_done_d  = 1'b0;
    seq_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && num_ok) begin
          state_d    = ST_LOAD;
          load_idx_d = '0;
        end
      end
      ST_LOAD: begin
        state_d     = ST_RUN;
        cfg_d       = seg_cfg_t'(rd_data[CFG_W-1:0]);
        entry_idx_d = load_idx_q;
        cnt_d       = (rd_dur == '0) ? DW'(1) : rd_dur;
        phase_rst_d = 1'b1;
      end
      ST_RUN: begin
        if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DW'(1)) begin
            seg_done_d = 1'b1;
            if (!last_entry) begin
              state_d    = ST_LOAD;
              load_idx_d = entry_idx_q + 1'b1;
            end else if (loop_en) begin
              state_d    = ST_LOAD;
              load_idx_d = '0;
            end else begin
              state_d    = ST_IDLE;
              seq_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // stop beats start; both abandon whatever the current state was doing
    if (state_q != ST_IDLE && (stop || (start && num_ok))) begin
      state_d     = stop ? ST_IDLE : ST_LOAD;
      load_idx_d  = stop ? load_idx_q : '0;
      cfg_d       = cfg_q;
      entry_idx_d = entry_idx_q;
      cnt_d       = cnt_q;
      phase_rst_d = 1'b0;
      seg_done_d  = 1'b0;
      seq_done_d  = 1'b0;
    end else if (state_q == ST_IDLE && stop) begin
      state_d    = ST_IDLE;
      load_idx_d = load_idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      entry_idx_q <= '0;
      load_idx_q  <= '0;
      cnt_q       <= '0;
      phase_rst_q <= 1'b0;
      seg_done_q  <= 1'b0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      entry_idx_q <= entry_idx_d;
      load_idx_q  <= load_idx_d;
      cnt_q       <= cnt_d;
      phase_rst_q <= phase_rst_d;
      seg_done_q  <= seg_done_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign wave_sel     = cfg_q.wave_sel;
  assign freq_wave    = cfg_q.freq_sel;
  assign amp_wave     = cfg_q.amp_sel;
  assign noise_enable = cfg_q.noise_en;
  assign entry_idx    = entry_idx_q;
  assign phase_rst    = phase_rst_q;
  assign seg_done     = seg_done_q;
  assign seq_done     = seq_done_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
